// File: rtl/dds_voice_bank.sv
// dds_voice_bank: time-multiplexed multi-voice DDS oscillator bank.
// One voice is evaluated per clock through a shared waveform stage, and the
// gated voice samples are summed into one unsigned mix sample per frame.
// Optional macro DDS_GATE_RAMP_EN: per-voice 8-bit amplitude ramp on gate
// changes, which adds one extra pipeline stage.
module dds_voice_bank #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24,
   parameter int OUT_W      = 8,
   parameter int LUT_AW     = 8,
   localparam int VW        = $clog2(NUM_VOICES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sample_tick,
   input  logic                cfg_we,
   input  logic [VW-1:0]       cfg_voice,
   input  logic [PHASE_W-1:0]  cfg_inc,
   input  logic [1:0]          cfg_wave,
   input  logic                cfg_gate,
   input  logic                cfg_phase_clr,
   output logic [OUT_W+VW-1:0] mix_out,
   output logic                mix_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int MW = OUT_W + VW;
   localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [MW-1:0] MIX_RST = MW'(NUM_VOICES) << (OUT_W - 1);

   typedef logic [OUT_W-1:0] rom_t [2**LUT_AW];

   // Sine table sits just below full scale so that it is symmetric about MID-0.5.
   function automatic rom_t gen_sine_rom();
      rom_t r;
      real  amp;
      real  ang;
      amp = real'(2**(OUT_W-1)) - 0.5;
      for (int k = 0; k < 2**LUT_AW; k++) begin
         ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(2**LUT_AW);
         r[k] = OUT_W'($rtoi(amp + amp * $sin(ang) + 0.5));
      end
      return r;
   endfunction

   localparam rom_t SINE_ROM = gen_sine_rom();

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t              state_q;
   logic [VW-1:0]       v_q;
   logic [MW-1:0]       acc_q;
   logic [MW-1:0]       mix_out_q;
   logic                mix_valid_q;
   logic                busy_q;
   logic                overrun_q;

   // Programmed configuration (written any time via cfg_we).
   logic [PHASE_W-1:0]  inc_q [NUM_VOICES];
   logic [PHASE_W-1:0]  inc_d [NUM_VOICES];
   logic [1:0]          wave_q [NUM_VOICES];
   logic [1:0]          wave_d [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] clr_pend_q, clr_pend_d;

   // Working copies frozen for the duration of a frame.
   logic [PHASE_W-1:0]  inc_w_q [NUM_VOICES];
   logic [PHASE_W-1:0]  inc_w_d [NUM_VOICES];
   logic [1:0]          wave_w_q [NUM_VOICES];
   logic [1:0]          wave_w_d [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_w_q, gate_w_d;
   logic [NUM_VOICES-1:0] clr_w_q, clr_w_d;

   logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]  phase_d [NUM_VOICES];

   logic                s1_val_q, s1_val_d;
   logic [OUT_W-1:0]    s1_smp_q, s1_smp_d;

   logic                start_s;
   logic                issue_s;
   logic [PHASE_W-1:0]  cur_phase_s;
   logic [OUT_W-1:0]    t_s;
   logic [OUT_W-1:0]    tri_sh_s;
   logic [OUT_W-1:0]    wave_s;
   logic                add_en_s;
   logic [OUT_W-1:0]    add_smp_s;
   logic                pipe_busy_s;

   assign start_s = (state_q == ST_IDLE) && sample_tick && en;
   assign issue_s = (state_q == ST_RUN);

   // A pending clear zeroes the phase before it is both sampled and advanced.
   assign cur_phase_s = clr_w_q[v_q] ? '0 : phase_q[v_q];
   assign t_s         = cur_phase_s[PHASE_W-1 -: OUT_W];
   assign tri_sh_s    = {t_s[OUT_W-2:0], 1'b0};

   // Configuration writes; pending clears are consumed at frame start, a same-cycle write re-arms.
   always_comb begin
      inc_d      = inc_q;
      wave_d     = wave_q;
      gate_d     = gate_q;
      clr_pend_d = start_s ? '0 : clr_pend_q;
      if (cfg_we) begin
         inc_d[cfg_voice]  = cfg_inc;
         wave_d[cfg_voice] = cfg_wave;
         gate_d[cfg_voice] = cfg_gate;
         if (cfg_phase_clr) begin
            clr_pend_d[cfg_voice] = 1'b1;
         end else begin
            clr_pend_d[cfg_voice] = clr_pend_d[cfg_voice];
         end
      end else begin
         gate_d = gate_q;
      end
   end

   // Snapshot the pre-write configuration into the working set at frame start.
   always_comb begin
      if (start_s) begin
         inc_w_d  = inc_q;
         wave_w_d = wave_q;
         gate_w_d = gate_q;
         clr_w_d  = clr_pend_q;
      end else begin
         inc_w_d  = inc_w_q;
         wave_w_d = wave_w_q;
         gate_w_d = gate_w_q;
         clr_w_d  = clr_w_q;
      end
   end

   // Advance the phase of the voice being issued this cycle.
   always_comb begin
      phase_d = phase_q;
      if (issue_s) begin
         phase_d[v_q] = cur_phase_s + inc_w_q[v_q];
      end else begin
         phase_d = phase_q;
      end
   end

   // Shared waveform generator for the voice being issued.
   always_comb begin
      case (wave_w_q[v_q])
         2'b00:   wave_s = SINE_ROM[t_s[OUT_W-1 -: LUT_AW]];
         2'b01:   wave_s = t_s[OUT_W-1] ? ~tri_sh_s : tri_sh_s;
         2'b10:   wave_s = t_s[OUT_W-1] ? '0 : '1;
         2'b11:   wave_s = t_s;
         default: wave_s = t_s;
      endcase
   end

`ifdef DDS_GATE_RAMP_EN
   logic [7:0]          amp_q [NUM_VOICES];
   logic [7:0]          amp_d [NUM_VOICES];
   logic [7:0]          s1_amp_q, s1_amp_d;
   logic                s2_val_q, s2_val_d;
   logic [OUT_W-1:0]    s2_smp_q, s2_smp_d;
   logic signed [OUT_W:0]   diff_s;
   logic signed [OUT_W+9:0] prod_s;
   logic signed [OUT_W+9:0] scaled_s;

   // Amplitudes step once per frame toward full scale or silence, saturating.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!start_s) begin
            amp_d[i] = amp_q[i];
         end else if (gate_q[i]) begin
            amp_d[i] = (amp_q[i] == 8'hFF) ? 8'hFF : amp_q[i] + 8'd1;
         end else begin
            amp_d[i] = (amp_q[i] == 8'h00) ? 8'h00 : amp_q[i] - 8'd1;
         end
      end
   end

   // Stage 1 carries the raw sample plus amplitude; stage 2 scales about midscale.
   always_comb begin
      s1_val_d = issue_s;
      s1_smp_d = wave_s;
      s1_amp_d = amp_q[v_q];
      diff_s   = $signed({1'b0, s1_smp_q}) - $signed({1'b0, MID});
      prod_s   = diff_s * $signed({1'b0, s1_amp_q});
      scaled_s = (prod_s >>> 8) + $signed({10'd0, MID});
      s2_val_d = s1_val_q;
      s2_smp_d = scaled_s[OUT_W-1:0];
   end

   // Ramp pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            amp_q[i] <= 8'd0;
         end
         s1_amp_q <= 8'd0;
         s2_val_q <= 1'b0;
         s2_smp_q <= '0;
      end else begin
         amp_q    <= amp_d;
         s1_amp_q <= s1_amp_d;
         s2_val_q <= s2_val_d;
         s2_smp_q <= s2_smp_d;
      end
   end

   assign add_en_s    = s2_val_q;
   assign add_smp_s   = s2_smp_q;
   assign pipe_busy_s = s1_val_q | s2_val_q;
`else
   // Gated-off voices contribute midscale so silence sits at the centre.
   always_comb begin
      s1_val_d = issue_s;
      s1_smp_d = gate_w_q[v_q] ? wave_s : MID;
   end

   assign add_en_s    = s1_val_q;
   assign add_smp_s   = s1_smp_q;
   assign pipe_busy_s = s1_val_q;
`endif

   // Voice state, working set and waveform stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            inc_q[i]    <= '0;
            wave_q[i]   <= 2'b00;
            inc_w_q[i]  <= '0;
            wave_w_q[i] <= 2'b00;
            phase_q[i]  <= '0;
         end
         gate_q     <= '0;
         clr_pend_q <= '0;
         gate_w_q   <= '0;
         clr_w_q    <= '0;
         s1_val_q   <= 1'b0;
         s1_smp_q   <= '0;
      end else begin
         inc_q      <= inc_d;
         wave_q     <= wave_d;
         gate_q     <= gate_d;
         clr_pend_q <= clr_pend_d;
         inc_w_q    <= inc_w_d;
         wave_w_q   <= wave_w_d;
         gate_w_q   <= gate_w_d;
         clr_w_q    <= clr_w_d;
         phase_q    <= phase_d;
         s1_val_q   <= s1_val_d;
         s1_smp_q   <= s1_smp_d;
      end
   end

   // Frame sequencer: issue voices, drain the pipeline, publish the mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         v_q         <= '0;
         acc_q       <= '0;
         mix_out_q   <= MIX_RST;
         mix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         if (sample_tick && en && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_q <= ST_RUN;
                  v_q     <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (add_en_s) begin
                  acc_q <= acc_q + {{VW{1'b0}}, add_smp_s};
               end
               v_q <= v_q + 1'b1;
               if (v_q == VW'(NUM_VOICES - 1)) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (add_en_s) begin
                  acc_q <= acc_q + {{VW{1'b0}}, add_smp_s};
               end
               if (!pipe_busy_s) begin
                  mix_out_q   <= acc_q;
                  mix_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mix_out   = mix_out_q;
   assign mix_valid = mix_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_dds_voice_bank.sv
// Self-checking bench for dds_voice_bank against a frame-level behavioural model.
module tb_dds_voice_bank;
   localparam int N   = 4;
   localparam int PW  = 24;
   localparam int OW  = 8;
   localparam int LA  = 8;
   localparam int VW  = 2;
   localparam int MID = 128;
`ifdef DDS_GATE_RAMP_EN
   localparam int LAT = N + 3;
`else
   localparam int LAT = N + 2;
`endif

   logic clk = 1'b0;
   logic rst, en, sample_tick, cfg_we, cfg_gate, cfg_phase_clr;
   logic [VW-1:0]    cfg_voice;
   logic [PW-1:0]    cfg_inc;
   logic [1:0]       cfg_wave;
   logic [OW+VW-1:0] mix_out;
   logic mix_valid, busy, overrun;

   dds_voice_bank #(.NUM_VOICES(N), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(LA)) dut (
      .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
      .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
      .cfg_wave(cfg_wave), .cfg_gate(cfg_gate), .cfg_phase_clr(cfg_phase_clr),
      .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   longint m_phase [N];
   longint m_inc [N];
   int     m_wave [N];
   bit     m_gate [N];
   bit     m_clr [N];
   int     m_amp [N];
   int     sine_tab [1 << LA];

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_phase[i] = 0; m_inc[i] = 0; m_wave[i] = 0;
         m_gate[i] = 0; m_clr[i] = 0; m_amp[i] = 0;
      end
   endtask

   function automatic int wave_of(input int w, input int t);
      case (w)
         0: return sine_tab[t >> (OW - LA)];
         1: return (t < MID) ? 2 * t : 2 * (1 << OW) - 1 - 2 * t;
         2: return (t < MID) ? (1 << OW) - 1 : 0;
         default: return t;
      endcase
   endfunction

   // One frame of the bank: returns the expected mix and advances model phases.
   task automatic frame_model(output int mix);
      int s, t;
      longint p;
      mix = 0;
      for (int i = 0; i < N; i++) begin
         p = m_clr[i] ? 0 : m_phase[i];
         m_clr[i] = 0;
         t = int'(p >> (PW - OW));
         s = wave_of(m_wave[i], t);
`ifdef DDS_GATE_RAMP_EN
         if (m_gate[i]) m_amp[i] = (m_amp[i] == 255) ? 255 : m_amp[i] + 1;
         else           m_amp[i] = (m_amp[i] == 0) ? 0 : m_amp[i] - 1;
         s = MID + (((s - MID) * m_amp[i]) >>> 8);
`else
         if (!m_gate[i]) s = MID;
`endif
         mix += s;
         m_phase[i] = (p + m_inc[i]) % (64'd1 << PW);
      end
   endtask

   // Advance one clock; a write presented during this cycle lands in the model afterwards.
   task automatic step();
      @(posedge clk);
      #1;
      if (cfg_we && !rst) begin
         m_inc[cfg_voice]  = longint'(cfg_inc);
         m_wave[cfg_voice] = int'(cfg_wave);
         m_gate[cfg_voice] = cfg_gate;
         if (cfg_phase_clr) m_clr[cfg_voice] = 1;
      end
      cfg_we = 1'b0;
      cfg_phase_clr = 1'b0;
   endtask

   task automatic set_cfg(input int v, input longint inc, input int w, input bit g, input bit c);
      cfg_we = 1'b1;
      cfg_voice = VW'(v);
      cfg_inc = PW'(inc);
      cfg_wave = 2'(w);
      cfg_gate = g;
      cfg_phase_clr = c;
   endtask

   task automatic tick_frame(input bit drop_en);
      int exp, lat;
      frame_model(exp);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check_eq("busy_after_tick", busy, 1);
      if (drop_en) en = 1'b0;
      lat = 0;
      while (!mix_valid && lat < 50) begin
         step();
         lat++;
      end
      check_eq("latency", lat, LAT);
      check_eq("mix", mix_out, exp);
      check_eq("busy_done", busy, 0);
      en = 1'b1;
      step();
      check_eq("valid_pulse", mix_valid, 0);
   endtask

   initial begin
      int exp, lat, nvalid, m0, ov0;
      real amp;
      amp = real'(MID) - 0.5;
      for (int k = 0; k < (1 << LA); k++)
         sine_tab[k] = $rtoi(amp + amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << LA)) + 0.5);

      rst = 1'b1; en = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
      cfg_voice = '0; cfg_inc = '0; cfg_wave = '0; cfg_gate = 1'b0; cfg_phase_clr = 1'b0;
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      step();
      check_eq("rst_mix", mix_out, N * MID);
      check_eq("rst_valid", mix_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_overrun", overrun, 0);

      // Saw ramp on voice 0, through one full wrap.
      set_cfg(0, 64'h010000, 3, 1, 0);
      step();
      for (int k = 0; k < 257; k++) begin
         tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
         check_eq("saw", mix_out, 384 + (k % 256));
`endif
      end

      // Square on voice 1 at half the sample rate.
      set_cfg(0, 64'h010000, 3, 0, 0);
      step();
      set_cfg(1, 64'h800000, 2, 1, 0);
      step();
      for (int k = 0; k < 6; k++) begin
         tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
         check_eq("square", mix_out, (k % 2 == 0) ? 639 : 384);
`endif
      end

      // Phase clear and a write landing on the tick cycle.
      set_cfg(1, 64'h800000, 2, 0, 0);
      step();
      set_cfg(0, 64'h010000, 3, 1, 1);
      step();
      tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
      check_eq("phase_clr", mix_out, 384);
`endif
      tick_frame(0);
      set_cfg(0, 64'h100000, 3, 1, 0);
      tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
      check_eq("old_inc", mix_out, 386);
`endif
      tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
      check_eq("old_inc2", mix_out, 387);
`endif
      tick_frame(0);
`ifndef DDS_GATE_RAMP_EN
      check_eq("new_inc", mix_out, 403);
`endif

      // Randomised configuration, gaps, same-cycle writes and en dropping mid-frame.
      for (int it = 0; it < 60; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) begin
            set_cfg($urandom_range(0, N - 1), longint'($urandom & 32'h00FF_FFFF),
                    $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            step();
         end
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 3) == 0)
            set_cfg($urandom_range(0, N - 1), longint'($urandom & 32'h00FF_FFFF),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
         tick_frame($urandom_range(0, 5) == 0);
      end

      // en low in IDLE: ticks ignored, outputs and phases frozen.
      m0 = int'(mix_out);
      ov0 = int'(overrun);
      en = 1'b0;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         if (mix_valid || busy) nvalid++;
         step();
      end
      check_eq("en_low_activity", nvalid, 0);
      check_eq("en_low_overrun", overrun, ov0);
      check_eq("en_low_hold", mix_out, m0);
      en = 1'b1;
      tick_frame(0);

      // Overrun: second tick two cycles into the frame is dropped.
      frame_model(exp);
      sample_tick = 1'b1; step();
      sample_tick = 1'b0; step();
      sample_tick = 1'b1; step();
      sample_tick = 1'b0;
      lat = 2;
      while (!mix_valid && lat < 50) begin
         step();
         lat++;
      end
      check_eq("ovr_latency", lat, LAT);
      check_eq("ovr_mix", mix_out, exp);
      nvalid = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (mix_valid) nvalid++;
      end
      check_eq("ovr_extra_valid", nvalid, 0);
      check_eq("ovr_sticky", overrun, 1);
      tick_frame(0);
      check_eq("ovr_sticky2", overrun, 1);

      // Reset in the middle of a frame.
      set_cfg(2, 64'h123456, 1, 1, 0);
      step();
      sample_tick = 1'b1; step();
      sample_tick = 1'b0; step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         if (mix_valid) nvalid++;
         step();
      end
      check_eq("rst_mid_valid", nvalid, 0);
      check_eq("rst_mid_mix", mix_out, 512);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_overrun", overrun, 0);
      tick_frame(0);
      check_eq("rst_clean_frame", mix_out, 512);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
